// File: rtl/bias_sweep_pkg.sv
// Shared types and default widths for the bias sweep sequencer.
// Holds the sequencer state encoding and the default bus widths.
// Imported by the top level and the settle timer.
package bias_sweep_pkg;

  localparam int DAC_W_DEF    = 12;
  localparam int ADC_W_DEF    = 12;
  localparam int SETTLE_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_EMIT   = 3'd4
  } bias_sweep_state_e;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter timing the analog settle window after each DAC load.
// Latency: count visible the cycle after load; zero flag is combinational on count.
// Backpressure: none; load wins over decrement, decrement stops at zero.
module settle_timer
  import bias_sweep_pkg::*;
#(
  parameter int SETTLE_W = SETTLE_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                dec,
  output logic                zero
);

  logic [SETTLE_W-1:0] cnt;

  // Reload on request, otherwise count down while enabled and saturate at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/bias_sweep_seq.sv
// DC bias sweep sequencer: steps a DAC code, settles, samples the probe ADC, streams (code, sample).
// Latency: per point settle+4 cycles with zero-wait ADC and consumer; done one cycle after last handshake.
// Backpressure: holds the result in EMIT until res_ready; ADC request held until adc_ack.
module bias_sweep_seq
  import bias_sweep_pkg::*;
#(
  parameter int DAC_W    = DAC_W_DEF,
  parameter int ADC_W    = ADC_W_DEF,
  parameter int SETTLE_W = SETTLE_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [DAC_W-1:0]    cfg_start,
  input  logic [DAC_W-1:0]    cfg_stop,
  input  logic [DAC_W-1:0]    cfg_step,
  input  logic [SETTLE_W-1:0] cfg_settle,
  output logic                busy,
  output logic                done,
  output logic [DAC_W-1:0]    dac_code,
  output logic                dac_load,
  output logic                adc_req,
  input  logic                adc_ack,
  input  logic [ADC_W-1:0]    adc_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DAC_W-1:0]    res_code,
  output logic [ADC_W-1:0]    res_data
);

  bias_sweep_state_e   state;
  logic [DAC_W-1:0]    code_q;
  logic [DAC_W-1:0]    stop_q;
  logic [DAC_W-1:0]    step_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [DAC_W-1:0]    res_code_q;
  logic [ADC_W-1:0]    res_data_q;
  logic                done_q;
  logic                tmr_zero;
  logic [DAC_W:0]      next_sum;
  logic                last_point;

  // One bit of headroom so a step past full scale ends the sweep instead of wrapping.
  assign next_sum   = {1'b0, code_q} + {1'b0, step_q};
  assign last_point = (next_sum > {1'b0, stop_q}) || (code_q >= stop_q);

  settle_timer #(
    .SETTLE_W (SETTLE_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == ST_LOAD),
    .load_val (settle_q),
    .dec      (state == ST_SETTLE),
    .zero     (tmr_zero)
  );

  // Sweep state machine; the code register doubles as the held DAC code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      code_q     <= '0;
      stop_q     <= '0;
      step_q     <= '0;
      settle_q   <= '0;
      res_code_q <= '0;
      res_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if ((state != ST_IDLE) && abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            // A start coinciding with the done pulse belongs to the old sweep and is dropped.
            if (start && !done_q) begin
              code_q   <= cfg_start;
              stop_q   <= cfg_stop;
              step_q   <= (cfg_step == '0) ? {{(DAC_W-1){1'b0}}, 1'b1} : cfg_step;
              settle_q <= cfg_settle;
              state    <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            state <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (tmr_zero) begin
              state <= ST_SAMPLE;
            end
          end
          ST_SAMPLE: begin
            if (adc_ack) begin
              res_code_q <= code_q;
              res_data_q <= adc_data;
              state      <= ST_EMIT;
            end
          end
          ST_EMIT: begin
            if (res_ready) begin
              if (last_point) begin
                done_q <= 1'b1;
                state  <= ST_IDLE;
              end else begin
                code_q <= next_sum[DAC_W-1:0];
                state  <= ST_LOAD;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = done_q;
  assign dac_code  = code_q;
  assign dac_load  = (state == ST_LOAD);
  assign adc_req   = (state == ST_SAMPLE);
  assign res_valid = (state == ST_EMIT);
  assign res_code  = res_code_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_bias_sweep_seq.sv
// Directed bench for bias_sweep_seq: table of sweeps plus hand-written corner sequences.
// Inputs driven 1 time unit after the rising edge; outputs sampled there and at the falling edge.
// The ADC is modelled as an optional zero-wait responder returning code ^ 0xA5A.
module tb_bias_sweep_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [11:0] cfg_start;
  logic [11:0] cfg_stop;
  logic [11:0] cfg_step;
  logic [15:0] cfg_settle;
  logic        busy;
  logic        done;
  logic [11:0] dac_code;
  logic        dac_load;
  logic        adc_req;
  logic        adc_ack;
  logic [11:0] adc_data;
  logic        res_valid;
  logic        res_ready;
  logic [11:0] res_code;
  logic [11:0] res_data;
  logic        adc_auto;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          load_cyc_q[$];
  logic [11:0] load_code_q[$];
  logic [11:0] rc_q[$];
  logic [11:0] rd_q[$];
  int          done_cnt = 0;
  int          done_busy_bad = 0;

  typedef struct packed {
    logic [11:0]      st;
    logic [11:0]      sp;
    logic [11:0]      stp;
    logic [15:0]      settle;
    logic [2:0]       n;
    logic [3:0][11:0] codes;
  } vec_t;

  vec_t vecs[6];

  bias_sweep_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .cfg_start  (cfg_start),
    .cfg_stop   (cfg_stop),
    .cfg_step   (cfg_step),
    .cfg_settle (cfg_settle),
    .busy       (busy),
    .done       (done),
    .dac_code   (dac_code),
    .dac_load   (dac_load),
    .adc_req    (adc_req),
    .adc_ack    (adc_ack),
    .adc_data   (adc_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_code   (res_code),
    .res_data   (res_data)
  );

  assign adc_ack  = adc_auto & adc_req;
  assign adc_data = dac_code ^ 12'hA5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: records loads, accepted results and done pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dac_load) begin
        load_cyc_q.push_back(cyc);
        load_code_q.push_back(dac_code);
      end
      if (res_valid && res_ready) begin
        rc_q.push_back(res_code);
        rd_q.push_back(res_data);
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        if (busy) done_busy_bad = done_busy_bad + 1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    int lb, rb, db, dbb, sc, n;
    v   = vecs[vi];
    lb  = load_cyc_q.size();
    rb  = rc_q.size();
    db  = done_cnt;
    dbb = done_busy_bad;
    cfg_start  = v.st;
    cfg_stop   = v.sp;
    cfg_step   = v.stp;
    cfg_settle = v.settle;
    start = 1'b1;
    sc = cyc;
    tick;
    start = 1'b0;
    n = 0;
    while (!done && n < 2000) begin
      tick;
      n++;
    end
    chk($sformatf("v%0d_done_seen", vi), 32'(done), 32'd1);
    tick;
    chk($sformatf("v%0d_busy_after", vi), 32'(busy), 32'd0);
    chk($sformatf("v%0d_nres", vi), 32'(rc_q.size() - rb), 32'(v.n));
    chk($sformatf("v%0d_nload", vi), 32'(load_cyc_q.size() - lb), 32'(v.n));
    chk($sformatf("v%0d_ndone", vi), 32'(done_cnt - db), 32'd1);
    chk($sformatf("v%0d_done_busy", vi), 32'(done_busy_bad - dbb), 32'd0);
    for (int k = 0; k < int'(v.n); k++) begin
      if (rb + k < rc_q.size()) begin
        chk($sformatf("v%0d_code%0d", vi, k), 32'(rc_q[rb+k]), 32'(v.codes[k]));
        chk($sformatf("v%0d_data%0d", vi, k), 32'(rd_q[rb+k]), 32'(v.codes[k] ^ 12'hA5A));
      end
      if (lb + k < load_cyc_q.size()) begin
        chk($sformatf("v%0d_dac%0d", vi, k), 32'(load_code_q[lb+k]), 32'(v.codes[k]));
        if (k == 0)
          chk($sformatf("v%0d_first_load", vi), 32'(load_cyc_q[lb] - sc), 32'd1);
        else
          chk($sformatf("v%0d_gap%0d", vi, k), 32'(load_cyc_q[lb+k] - load_cyc_q[lb+k-1]),
              32'(v.settle) + 32'd4);
      end
    end
  endtask

  initial begin
    int n, lb, rb, db;
    logic [11:0] hc, hd;

    vecs[0] = '{st: 12'h100, sp: 12'h130, stp: 12'h010, settle: 16'd3, n: 3'd4,
                codes: {12'h130, 12'h120, 12'h110, 12'h100}};
    vecs[1] = '{st: 12'hFF0, sp: 12'hFFF, stp: 12'h008, settle: 16'd0, n: 3'd2,
                codes: {12'h000, 12'h000, 12'hFF8, 12'hFF0}};
    vecs[2] = '{st: 12'h200, sp: 12'h100, stp: 12'h010, settle: 16'd1, n: 3'd1,
                codes: {12'h000, 12'h000, 12'h000, 12'h200}};
    vecs[3] = '{st: 12'h010, sp: 12'h012, stp: 12'h000, settle: 16'd0, n: 3'd3,
                codes: {12'h000, 12'h012, 12'h011, 12'h010}};
    vecs[4] = '{st: 12'h000, sp: 12'h030, stp: 12'h018, settle: 16'd2, n: 3'd3,
                codes: {12'h000, 12'h030, 12'h018, 12'h000}};
    vecs[5] = '{st: 12'h000, sp: 12'h025, stp: 12'h010, settle: 16'd5, n: 3'd3,
                codes: {12'h000, 12'h020, 12'h010, 12'h000}};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b1; adc_auto = 1'b1;
    cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_settle = '0;
    tick; tick;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dac_code", 32'(dac_code), 32'd0);
    chk("rst_dac_load", 32'(dac_load), 32'd0);
    chk("rst_adc_req", 32'(adc_req), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_code", 32'(res_code), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 6; i++) begin
      run_vec(i);
      tick;
    end

    // Backpressure: result must hold while the consumer stalls.
    rb = rc_q.size();
    lb = load_cyc_q.size();
    res_ready = 1'b0;
    cfg_start = 12'h100; cfg_stop = 12'h110; cfg_step = 12'h010; cfg_settle = 16'd1;
    start = 1'b1; tick; start = 1'b0;
    n = 0;
    while (!res_valid && n < 100) begin tick; n++; end
    chk("bp_valid_seen", 32'(res_valid), 32'd1);
    hc = 12'h100;
    hd = 12'h100 ^ 12'hA5A;
    for (int c = 0; c < 10; c++) begin
      tick;
      chk($sformatf("bp_valid_c%0d", c), 32'(res_valid), 32'd1);
      chk($sformatf("bp_code_c%0d", c), 32'(res_code), 32'(hc));
      chk($sformatf("bp_data_c%0d", c), 32'(res_data), 32'(hd));
      chk($sformatf("bp_load_c%0d", c), 32'(dac_load), 32'd0);
      chk($sformatf("bp_req_c%0d", c), 32'(adc_req), 32'd0);
    end
    res_ready = 1'b1;
    n = 0;
    while (!done && n < 100) begin tick; n++; end
    chk("bp_done_seen", 32'(done), 32'd1);
    tick;
    chk("bp_nres", 32'(rc_q.size() - rb), 32'd2);
    chk("bp_nload", 32'(load_cyc_q.size() - lb), 32'd2);
    if (rc_q.size() >= rb + 2) chk("bp_code1", 32'(rc_q[rb+1]), 32'h110);

    // Abort in SETTLE of the second point.
    rb = rc_q.size();
    lb = load_cyc_q.size();
    db = done_cnt;
    cfg_start = 12'h100; cfg_stop = 12'h140; cfg_step = 12'h010; cfg_settle = 16'd5;
    start = 1'b1; tick; start = 1'b0;
    n = 0;
    while (!(dac_load && dac_code == 12'h110) && n < 100) begin tick; n++; end
    chk("ab_second_load", 32'(dac_load), 32'd1);
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    chk("ab_res_valid", 32'(res_valid), 32'd0);
    chk("ab_dac_code", 32'(dac_code), 32'h110);
    for (int c = 0; c < 20; c++) tick;
    chk("ab_nres", 32'(rc_q.size() - rb), 32'd1);
    chk("ab_nload", 32'(load_cyc_q.size() - lb), 32'd2);
    chk("ab_ndone", 32'(done_cnt - db), 32'd0);
    chk("ab_dac_hold", 32'(dac_code), 32'h110);

    // Reset during SAMPLE, then a clean sweep.
    adc_auto = 1'b0;
    cfg_start = 12'h300; cfg_stop = 12'h330; cfg_step = 12'h010; cfg_settle = 16'd2;
    start = 1'b1; tick; start = 1'b0;
    n = 0;
    while (!adc_req && n < 100) begin tick; n++; end
    chk("rs_in_sample", 32'(adc_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_dac_code", 32'(dac_code), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_adc_req", 32'(adc_req), 32'd0);
    chk("rs_res_valid", 32'(res_valid), 32'd0);
    chk("rs_res_code", 32'(res_code), 32'd0);
    chk("rs_dac_load", 32'(dac_load), 32'd0);
    tick;
    rst_n = 1'b1;
    adc_auto = 1'b1;
    tick;
    run_vec(0);
    tick;

    // Start coinciding with the done pulse is ignored.
    cfg_start = 12'h200; cfg_stop = 12'h100; cfg_step = 12'h010; cfg_settle = 16'd1;
    start = 1'b1; tick; start = 1'b0;
    n = 0;
    while (!done && n < 100) begin tick; n++; end
    chk("sd_done_seen", 32'(done), 32'd1);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("sd_busy", 32'(busy), 32'd0);
    chk("sd_dac_load", 32'(dac_load), 32'd0);
    tick;
    chk("sd_busy2", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
